// File: rtl/bp_dma_arbiter.sv
// Two-master arbiter for the single bsg_cache DMA channel of the DDR3 controller.
// Grants whole transactions (packet plus all data beats) round-robin once calibration is done.
module bp_dma_arbiter #(
    parameter int dma_pkt_width_p = 32,
    parameter int data_width_p    = 64,
    parameter int beats_p         = 2
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 calib_done_i,

    input  logic [1:0][dma_pkt_width_p-1:0]      req_dma_pkt_i,
    input  logic [1:0]                           req_dma_pkt_v_i,
    output logic [1:0]                           req_dma_pkt_yumi_o,

    output logic [data_width_p-1:0]              req_dma_data_o,
    output logic [1:0]                           req_dma_data_v_o,
    input  logic [1:0]                           req_dma_data_ready_and_i,

    input  logic [1:0][data_width_p-1:0]         req_dma_data_i,
    input  logic [1:0]                           req_dma_data_v_i,
    output logic [1:0]                           req_dma_data_yumi_o,

    output logic [dma_pkt_width_p-1:0]           dma_pkt_o,
    output logic                                 dma_pkt_v_o,
    input  logic                                 dma_pkt_yumi_i,

    input  logic [data_width_p-1:0]              dma_data_i,
    input  logic                                 dma_data_v_i,
    output logic                                 dma_data_ready_and_o,

    output logic [data_width_p-1:0]              dma_data_o,
    output logic                                 dma_data_v_o,
    input  logic                                 dma_data_yumi_i,

    output logic                                 grant_id_o,
    output logic                                 busy_o
);

    localparam int beat_width_lp = (beats_p > 1) ? $clog2(beats_p) : 1;
    localparam logic [beat_width_lp-1:0] last_beat_lp = beat_width_lp'(beats_p - 1);

    localparam logic [1:0] state_idle    = 2'd0;
    localparam logic [1:0] state_issue   = 2'd1;
    localparam logic [1:0] state_rd_data = 2'd2;
    localparam logic [1:0] state_wr_data = 2'd3;

    logic [1:0]               state_r;
    logic                     grant_r;
    logic                     last_r;
    logic                     wnr_r;
    logic [beat_width_lp-1:0] beat_r;

    logic                     winner_s;
    logic                     pkt_fire_s;
    logic                     beat_fire_s;
    logic                     pkt_wnr_s;

    // Round-robin pick: on a tie the requester that was not served last wins.
    always_comb begin
        if (&req_dma_pkt_v_i) begin
            winner_s = ~last_r;
        end else begin
            winner_s = req_dma_pkt_v_i[1];
        end
    end

    assign pkt_fire_s  = (state_r == state_issue) & dma_pkt_v_o & dma_pkt_yumi_i;
    assign pkt_wnr_s   = dma_pkt_o[dma_pkt_width_p-1];
    assign beat_fire_s = ((state_r == state_rd_data) & dma_data_v_i & dma_data_ready_and_o)
                       | ((state_r == state_wr_data) & dma_data_v_o & dma_data_yumi_i);

    // Transaction sequencing: grant, packet issue, then count data beats to the terminal one.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= state_idle;
            grant_r <= 1'b0;
            last_r  <= 1'b1;
            wnr_r   <= 1'b0;
            beat_r  <= '0;
        end else begin
            case (state_r)
                state_idle: begin
                    if (calib_done_i && (|req_dma_pkt_v_i)) begin
                        grant_r <= winner_s;
                        state_r <= state_issue;
                    end
                end
                state_issue: begin
                    if (pkt_fire_s) begin
                        last_r  <= grant_r;
                        beat_r  <= '0;
                        wnr_r   <= pkt_wnr_s;
                        state_r <= pkt_wnr_s ? state_wr_data : state_rd_data;
                    end
                end
                state_rd_data, state_wr_data: begin
                    if (beat_fire_s) begin
                        if (beat_r == last_beat_lp) begin
                            state_r <= state_idle;
                        end else begin
                            beat_r <= beat_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= state_idle;
                end
            endcase
        end
    end

    // Pure muxing of handshakes and data toward the granted requester; nothing is buffered.
    always_comb begin
        dma_pkt_o            = req_dma_pkt_i[grant_r];
        dma_pkt_v_o          = 1'b0;
        req_dma_pkt_yumi_o   = 2'b00;
        req_dma_data_o       = dma_data_i;
        req_dma_data_v_o     = 2'b00;
        dma_data_ready_and_o = 1'b0;
        dma_data_o           = req_dma_data_i[grant_r];
        dma_data_v_o         = 1'b0;
        req_dma_data_yumi_o  = 2'b00;
        case (state_r)
            state_issue: begin
                dma_pkt_v_o                 = req_dma_pkt_v_i[grant_r];
                req_dma_pkt_yumi_o[grant_r] = dma_pkt_yumi_i;
            end
            state_rd_data: begin
                req_dma_data_v_o[grant_r] = dma_data_v_i;
                dma_data_ready_and_o      = req_dma_data_ready_and_i[grant_r];
            end
            state_wr_data: begin
                dma_data_v_o                 = req_dma_data_v_i[grant_r];
                req_dma_data_yumi_o[grant_r] = dma_data_yumi_i;
            end
            default: begin
                dma_pkt_v_o = 1'b0;
            end
        endcase
    end

    assign grant_id_o = grant_r;
    assign busy_o     = (state_r != state_idle);

    logic unused_wnr_s;
    assign unused_wnr_s = wnr_r;

endmodule

// File: tb/tb_bp_dma_arbiter.sv
// Directed bench for bp_dma_arbiter: transaction-level model compared every cycle,
// plus literal expectations for the calibration gate, grant order and beat counts.
module tb_bp_dma_arbiter;

    localparam int PW    = 16;
    localparam int DW    = 16;
    localparam int BEATS = 3;

    logic                 clk = 1'b0;
    logic                 reset_i;
    logic                 calib;
    logic [1:0][PW-1:0]   req_pkt;
    logic [1:0]           req_pkt_v;
    logic [1:0]           req_pkt_yumi;
    logic [DW-1:0]        req_rdata;
    logic [1:0]           req_rdata_v;
    logic [1:0]           req_rd_ready;
    logic [1:0][DW-1:0]   req_wdata;
    logic [1:0]           req_wdata_v;
    logic [1:0]           req_wdata_yumi;
    logic [PW-1:0]        dma_pkt;
    logic                 dma_pkt_v;
    logic                 dma_pkt_yumi;
    logic [DW-1:0]        ctl_rdata;
    logic                 ctl_rdata_v;
    logic                 dma_rd_ready;
    logic [DW-1:0]        dma_wdata;
    logic                 dma_wdata_v;
    logic                 dma_wdata_yumi;
    logic                 grant_id;
    logic                 busy;

    logic pkt_yumi_en;
    logic wr_yumi_en;
    logic toggle_ready;

    always #5 clk = ~clk;

    assign dma_pkt_yumi   = dma_pkt_v & pkt_yumi_en;
    assign dma_wdata_yumi = dma_wdata_v & wr_yumi_en;

    bp_dma_arbiter #(.dma_pkt_width_p(PW), .data_width_p(DW), .beats_p(BEATS)) dut (
        .clk_i(clk), .reset_i(reset_i), .calib_done_i(calib),
        .req_dma_pkt_i(req_pkt), .req_dma_pkt_v_i(req_pkt_v), .req_dma_pkt_yumi_o(req_pkt_yumi),
        .req_dma_data_o(req_rdata), .req_dma_data_v_o(req_rdata_v),
        .req_dma_data_ready_and_i(req_rd_ready),
        .req_dma_data_i(req_wdata), .req_dma_data_v_i(req_wdata_v), .req_dma_data_yumi_o(req_wdata_yumi),
        .dma_pkt_o(dma_pkt), .dma_pkt_v_o(dma_pkt_v), .dma_pkt_yumi_i(dma_pkt_yumi),
        .dma_data_i(ctl_rdata), .dma_data_v_i(ctl_rdata_v), .dma_data_ready_and_o(dma_rd_ready),
        .dma_data_o(dma_wdata), .dma_data_v_o(dma_wdata_v), .dma_data_yumi_i(dma_wdata_yumi),
        .grant_id_o(grant_id), .busy_o(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Requester packet queues and handshake observations
    logic [PW-1:0] q0[$];
    logic [PW-1:0] q1[$];
    logic [1:0]    pkt_taken = 2'b00;
    logic [1:0]    wdata_taken = 2'b00;
    int            grant_log[$];
    int            pktv_cnt = 0;
    int            rd_cnt[2] = '{0, 0};
    int            wr_cnt[2] = '{0, 0};
    bit            chk_on = 1'b0;

    // Transaction-level model: phase 0 idle, 1 packet, 2 data
    int m_phase, m_grant, m_last, m_left;
    bit m_write;

    function automatic int log_at(input int k);
        if (k < grant_log.size()) return grant_log[k];
        return 99;
    endfunction

    task automatic drive_req();
        req_pkt_v[0] = (q0.size() > 0);
        req_pkt_v[1] = (q1.size() > 0);
        req_pkt[0]   = (q0.size() > 0) ? q0[0] : '0;
        req_pkt[1]   = (q1.size() > 0) ? q1[0] : '0;
    endtask

    task automatic push(input int i, input logic [PW-1:0] p);
        if (i == 0) q0.push_back(p);
        else        q1.push_back(p);
        drive_req();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pkt_taken[0] && q0.size() > 0) void'(q0.pop_front());
        if (pkt_taken[1] && q1.size() > 0) void'(q1.pop_front());
        pkt_taken = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (wdata_taken[i]) req_wdata[i] = req_wdata[i] + 16'd1;
        end
        wdata_taken = 2'b00;
        ctl_rdata = ctl_rdata + 16'd1;
        if (toggle_ready) req_rd_ready[0] = ~req_rd_ready[0];
        drive_req();
    endtask

    task automatic wait_done(input int bound, input string nm);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy) && n < bound) begin
            step();
            n++;
        end
        chk(nm, {31'd0, (n < bound)}, 32'd1);
    endtask

    // Per-cycle compare against the model, then advance the model
    initial begin
        forever begin
            @(negedge clk);
            pkt_taken   = req_pkt_yumi;
            wdata_taken = req_wdata_yumi;
            if (dma_pkt_v) pktv_cnt++;
            if (req_pkt_yumi != 2'b00) grant_log.push_back(int'(grant_id));
            for (int i = 0; i < 2; i++) begin
                if (req_rdata_v[i] && req_rd_ready[i]) rd_cnt[i]++;
                if (req_wdata_yumi[i]) wr_cnt[i]++;
            end
            if (chk_on) begin
                bit e_pkt_v, e_pkt_yumi, rd, wr, e_ready, e_rdv, e_dv, e_dyumi, fire;
                e_pkt_v    = (m_phase == 1) && req_pkt_v[m_grant];
                e_pkt_yumi = e_pkt_v && pkt_yumi_en;
                rd         = (m_phase == 2) && !m_write;
                wr         = (m_phase == 2) && m_write;
                e_ready    = rd && req_rd_ready[m_grant];
                e_rdv      = rd && ctl_rdata_v;
                e_dv       = wr && req_wdata_v[m_grant];
                e_dyumi    = e_dv && wr_yumi_en;
                fire       = (e_rdv && e_ready) || e_dyumi;
                chk("busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
                chk("grant_id", {31'd0, grant_id}, m_grant);
                chk("dma_pkt_v", {31'd0, dma_pkt_v}, {31'd0, e_pkt_v});
                chk("req_pkt_yumi", {30'd0, req_pkt_yumi}, e_pkt_yumi ? (32'd1 << m_grant) : 32'd0);
                chk("dma_rd_ready", {31'd0, dma_rd_ready}, {31'd0, e_ready});
                chk("req_rdata_v", {30'd0, req_rdata_v}, e_rdv ? (32'd1 << m_grant) : 32'd0);
                chk("dma_wdata_v", {31'd0, dma_wdata_v}, {31'd0, e_dv});
                chk("req_wdata_yumi", {30'd0, req_wdata_yumi}, e_dyumi ? (32'd1 << m_grant) : 32'd0);
                if (m_phase == 1) chk("dma_pkt", {16'd0, dma_pkt}, {16'd0, req_pkt[m_grant]});
                if (rd)           chk("req_rdata", {16'd0, req_rdata}, {16'd0, ctl_rdata});
                if (wr)           chk("dma_wdata", {16'd0, dma_wdata}, {16'd0, req_wdata[m_grant]});
                if (reset_i) begin
                    m_phase = 0; m_grant = 0; m_last = 1;
                end else if (m_phase == 0) begin
                    if (calib && req_pkt_v != 2'b00) begin
                        m_grant = (req_pkt_v == 2'b11) ? 1 - m_last : (req_pkt_v[1] ? 1 : 0);
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (e_pkt_yumi) begin
                        m_last  = m_grant;
                        m_write = req_pkt[m_grant][PW-1];
                        m_left  = BEATS;
                        m_phase = 2;
                    end
                end else if (fire) begin
                    m_left--;
                    if (m_left == 0) m_phase = 0;
                end
            end
        end
    end

    initial begin
        reset_i = 1'b1; calib = 1'b0;
        req_pkt = '0; req_pkt_v = 2'b00;
        req_rd_ready = 2'b11; req_wdata[0] = 16'h1000; req_wdata[1] = 16'h2000;
        req_wdata_v = 2'b00; ctl_rdata = 16'h5000; ctl_rdata_v = 1'b1;
        pkt_yumi_en = 1'b1; wr_yumi_en = 1'b1; toggle_ready = 1'b0;
        m_phase = 0; m_grant = 0; m_last = 1; m_left = 0; m_write = 1'b0;
        repeat (3) step();
        reset_i = 1'b0;
        chk_on = 1'b1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset grant_id", {31'd0, grant_id}, 32'd0);
        chk("reset req_rdata_v", {30'd0, req_rdata_v}, 32'd0);

        // Calibration gate
        pktv_cnt = 0;
        push(0, 16'h0011);
        repeat (20) step();
        chk("calib gate pkt_v count", pktv_cnt, 32'd0);
        calib = 1'b1;
        step();
        @(negedge clk);
        chk("calib rise pkt_v", {31'd0, dma_pkt_v}, 32'd1);
        chk("calib rise pkt", {16'd0, dma_pkt}, 32'h0011);
        wait_done(40, "calib txn timeout");

        // Simultaneous reads from reset: req0 first
        reset_i = 1'b1; step(); step(); reset_i = 1'b0;
        grant_log.delete(); rd_cnt = '{0, 0};
        push(0, 16'h0022); push(1, 16'h0033);
        wait_done(60, "dual read timeout");
        chk("dual read log size", grant_log.size(), 32'd2);
        chk("dual read grant0", log_at(0), 32'd0);
        chk("dual read grant1", log_at(1), 32'd1);
        chk("dual read beats req0", rd_cnt[0], BEATS);
        chk("dual read beats req1", rd_cnt[1], BEATS);

        // Write from req1 with gapped controller yumi; early write data held
        wr_cnt = '{0, 0}; req_wdata_v = 2'b11; wr_yumi_en = 1'b0;
        push(1, 16'h8044);
        step();
        step();
        wr_yumi_en = 1'b1; step();
        wr_yumi_en = 1'b0; step(); step();
        wr_yumi_en = 1'b1; step(); step();
        chk("write done busy", {31'd0, busy}, 32'd0);
        chk("write yumi req1", wr_cnt[1], 32'd3);
        chk("write yumi req0", wr_cnt[0], 32'd0);

        // Read backpressure with toggling ready
        rd_cnt = '{0, 0}; toggle_ready = 1'b1;
        push(0, 16'h0055);
        wait_done(60, "backpressure timeout");
        chk("backpressure beats", rd_cnt[0], BEATS);
        toggle_ready = 1'b0; req_rd_ready = 2'b11;

        // Reset after the first read beat
        push(0, 16'h0066);
        step();
        step();
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("mid reset busy", {31'd0, busy}, 32'd0);
        chk("mid reset rdata_v", {30'd0, req_rdata_v}, 32'd0);
        chk("mid reset rd_ready", {31'd0, dma_rd_ready}, 32'd0);
        chk("mid reset pkt_v", {31'd0, dma_pkt_v}, 32'd0);
        grant_log.delete();
        push(0, 16'h0077); push(1, 16'h0088);
        wait_done(60, "post reset timeout");
        chk("post reset grant0", log_at(0), 32'd0);
        chk("post reset grant1", log_at(1), 32'd1);

        // Fairness across four transactions including a write
        grant_log.delete();
        push(0, 16'h00A1); push(0, 16'h00A2);
        push(1, 16'h80B1); push(1, 16'h00B2);
        wait_done(120, "fairness timeout");
        chk("fair log size", grant_log.size(), 32'd4);
        chk("fair grant0", log_at(0), 32'd0);
        chk("fair grant1", log_at(1), 32'd1);
        chk("fair grant2", log_at(2), 32'd0);
        chk("fair grant3", log_at(3), 32'd1);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
